trdb_cfg_master: RTL

- Register-bus initiator that drives the trace debugger's peripheral register port (per_valid/per_we/per_addr/per_wdata, per_rdata/per_ready).
- Accepts a stream of commands (write, read, poll-until-match) from a boot sequencer or debug bridge and executes them one at a time on the bus.
- Returns exactly one response per command.
- Typical use: program filter/address ranges, set TRDB_ENABLE, then poll CTRL until TRDB_FLUSH_STREAM clears.

---
 rtl/trdb_cfg_master.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/trdb_cfg_master.sv
// trdb_cfg_master: command-driven register-bus initiator (write/read/poll) for the trace debugger peripheral port.
// Optional access timeout is compiled in when TRDB_CFG_ACCESS_TIMEOUT_EN is defined.
module trdb_cfg_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int POLL_INTERVAL  = 4,
    parameter int POLL_MAX_TRIES = 16,
    parameter int ACCESS_TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_data_i,
    input  logic [31:0]               cmd_mask_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      per_valid_o,
    output logic                      per_we_o,
    output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
    output logic [31:0]               per_wdata_o,
    input  logic [31:0]               per_rdata_i,
    input  logic                      per_ready_i,
    output logic                      busy_o
);

    localparam int TW = $clog2(POLL_MAX_TRIES + 1);
    localparam int WW = $clog2(POLL_INTERVAL + 1);
    localparam logic [TW-1:0] TRY_LAST  = TW'(POLL_MAX_TRIES - 1);
    localparam logic [TW-1:0] TRY_MAX   = TW'(POLL_MAX_TRIES);
    localparam logic [WW-1:0] WAIT_LAST = WW'(POLL_INTERVAL - 1);
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    if (POLL_INTERVAL < 1 || POLL_MAX_TRIES < 1 || ACCESS_TIMEOUT < 1) begin : g_bad_param
        $error("trdb_cfg_master: POLL_INTERVAL, POLL_MAX_TRIES and ACCESS_TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               data_q, data_d;
    logic [31:0]               mask_q, mask_d;
    logic [TW-1:0]             try_q, try_d;
    logic [WW-1:0]             wait_q, wait_d;
    logic [31:0]               rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      match;

    assign match = ((per_rdata_i ^ data_q) & mask_q) == '0;

`ifdef TRDB_CFG_ACCESS_TIMEOUT_EN
    localparam int SW = $clog2(ACCESS_TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(ACCESS_TIMEOUT - 1);
    logic [SW-1:0] stall_q, stall_d;

    // stall counter: counts unanswered ACCESS cycles, zero whenever not in ACCESS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_q <= '0;
        else         stall_q <= stall_d;
    end
`endif

    // state and command/response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            try_q      <= '0;
            wait_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            try_q      <= try_d;
            wait_q     <= wait_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // next-state: accept, access (with poll retry), interval wait, response hold
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        try_d      = try_q;
        wait_d     = wait_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef TRDB_CFG_ACCESS_TIMEOUT_EN
        stall_d    = (state_q == ACCESS && !per_ready_i) ? stall_q + 1'b1 : '0;
`endif
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                op_d       = cmd_op_i;
                addr_d     = cmd_addr_i;
                data_d     = cmd_data_i;
                mask_d     = cmd_mask_i;
                try_d      = '0;
                rsp_data_d = '0;
                rsp_err_d  = cmd_op_i == OP_RSVD;
                state_d    = (cmd_op_i == OP_RSVD) ? RESP : ACCESS;
            end
            ACCESS: if (per_ready_i) begin
                rsp_data_d = (op_q == OP_WRITE) ? '0 : per_rdata_i;
                rsp_err_d  = 1'b0;
                if (op_q != OP_POLL || match) begin
                    state_d = RESP;
                end else if (try_q == TRY_LAST) begin
                    state_d   = RESP;
                    rsp_err_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    wait_d  = '0;
                    try_d   = (try_q == TRY_MAX) ? try_q : try_q + 1'b1;
                end
            end
`ifdef TRDB_CFG_ACCESS_TIMEOUT_EN
            else if (stall_q == STALL_LAST) begin
                state_d    = RESP;
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
            end
`endif
            WAIT: if (wait_q == WAIT_LAST) state_d = ACCESS;
                  else wait_d = wait_q + 1'b1;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o = rst_ni && state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign per_valid_o = state_q == ACCESS;
    assign per_we_o    = state_q == ACCESS && op_q == OP_WRITE;
    assign per_addr_o  = addr_q;
    assign per_wdata_o = data_q;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
